// File: rtl/fifo_axis_pkg.sv
// Shared definitions for the AXI-Stream framer.
//   state_t    : framer FSM states (idle, streaming FIFO data, padding)
//   TUSER_SOF  : tuser bit marking the first beat of a frame
//   TUSER_PAD  : tuser bit marking a zero pad beat
package fifo_axis_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_PAD    = 2'd2
    } state_t;

    localparam int TUSER_SOF = 0;
    localparam int TUSER_PAD = 1;

endpackage

// File: rtl/axis_skid2.sv
// Two-entry output buffer between the framer and the AXI-Stream master port.
// Head entry drives the outputs; entries leave in load order.
//   clk, srst     : clock and synchronous active-high reset
//   i_load        : write i_data (ignored when full)
//   i_unload      : drop the head entry (ignored when empty)
//   i_data        : entry to write
//   o_data        : head entry, held until unloaded
//   o_occupancy   : registered entry count, 0..2
module axis_skid2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             i_load,
    input  logic             i_unload,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data,
    output logic [1:0]       o_occupancy
);

    logic [WIDTH-1:0] r_head;
    logic [WIDTH-1:0] r_tail;
    logic [1:0]       r_occ;
    logic             w_load;
    logic             w_unload;

    assign w_load   = i_load && (r_occ != 2'd2);
    assign w_unload = i_unload && (r_occ != 2'd0);

    always_ff @(posedge clk) begin
        if (srst) begin
            r_head <= '0;
            r_tail <= '0;
            r_occ  <= 2'd0;
        end else begin
            case (r_occ)
                2'd0: begin
                    if (w_load) begin
                        r_head <= i_data;
                        r_occ  <= 2'd1;
                    end
                end
                2'd1: begin
                    // Load and unload together replaces the head in place,
                    // sustaining one beat per cycle at occupancy 1.
                    if (w_load && w_unload) begin
                        r_head <= i_data;
                    end else if (w_load) begin
                        r_tail <= i_data;
                        r_occ  <= 2'd2;
                    end else if (w_unload) begin
                        r_occ  <= 2'd0;
                    end
                end
                default: begin
                    if (w_unload) begin
                        r_head <= r_tail;
                        r_occ  <= 2'd1;
                    end
                end
            endcase
        end
    end

    assign o_data      = r_head;
    assign o_occupancy = r_occ;

endmodule

// File: rtl/fifo_axis_framer.sv
// Pops a show-ahead FIFO, zero-extends each word to the stream width and
// emits fixed-length AXI-Stream frames (tuser[0] on first beat, tlast on
// last beat, tuser[1] on pad beats used to close a flushed frame).
//   aclk_i, areset_i     : clock, synchronous active-high reset
//   enable_i             : start/continue framing, honoured at frame boundaries
//   flush_i              : close a partial frame with zero pad beats
//   fifoEmpty_i/Dout_i   : show-ahead FIFO status and data
//   fifoRd_o             : FIFO pop strobe
//   m_axis_*             : AXI-Stream master (tvalid/tready/tdata/tlast/tuser)
//   busy_o               : framer active or output buffer non-empty
//   frame_cnt_o          : completed frames (tlast handshakes), wraps at 2^32
module fifo_axis_framer
    import fifo_axis_pkg::*;
#(
    parameter int FIFO_WIDTH = 100,
    parameter int AXIS_WIDTH = 128,
    parameter int FRAME_LEN  = 256
) (
    input  logic                  aclk_i,
    input  logic                  areset_i,
    input  logic                  enable_i,
    input  logic                  flush_i,
    input  logic                  fifoEmpty_i,
    input  logic [FIFO_WIDTH-1:0] fifoDout_i,
    output logic                  fifoRd_o,
    output logic                  m_axis_tvalid_o,
    input  logic                  m_axis_tready_i,
    output logic [AXIS_WIDTH-1:0] m_axis_tdata_o,
    output logic                  m_axis_tlast_o,
    output logic [1:0]            m_axis_tuser_o,
    output logic                  busy_o,
    output logic [31:0]           frame_cnt_o
);

    localparam int                BEAT_W    = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(FRAME_LEN - 1);
    localparam int                SKID_W    = AXIS_WIDTH + 3;

    state_t              r_state;
    state_t              w_state_next;
    logic [BEAT_W-1:0]   r_beat_cnt;
    logic                r_flush_pend;
    logic                w_flush_pend_next;
    logic [31:0]         r_frame_cnt;

    logic                w_load;
    logic                w_fifo_rd;
    logic                w_can_load;
    logic                w_beat_last;
    logic                w_flush;
    logic                w_handshake;
    logic [1:0]          w_occ;
    logic [AXIS_WIDTH-1:0] w_beat_data;
    logic [1:0]          w_beat_user;
    logic [SKID_W-1:0]   w_skid_in;
    logic [SKID_W-1:0]   w_skid_out;

    // Load eligibility uses only the registered occupancy, so tready never
    // reaches fifoRd_o combinationally.
    assign w_can_load  = (w_occ < 2'd2);
    assign w_beat_last = (r_beat_cnt == LAST_BEAT);
    // A flush request is remembered until the FIFO drains; at a frame
    // boundary there is nothing to close, so it is dropped.
    assign w_flush     = (flush_i || r_flush_pend) && (r_beat_cnt != '0);

    always_comb begin
        w_state_next      = r_state;
        w_flush_pend_next = r_flush_pend;
        w_load            = 1'b0;
        w_fifo_rd         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_flush_pend_next = 1'b0;
                if (enable_i) begin
                    w_state_next = ST_STREAM;
                end
            end
            ST_STREAM: begin
                w_load    = w_can_load && !fifoEmpty_i;
                w_fifo_rd = w_load;
                if (w_load && w_beat_last) begin
                    w_state_next      = enable_i ? ST_STREAM : ST_IDLE;
                    w_flush_pend_next = 1'b0;
                end else if (w_flush && fifoEmpty_i) begin
                    w_state_next      = ST_PAD;
                    w_flush_pend_next = 1'b0;
                end else if (w_flush) begin
                    w_flush_pend_next = 1'b1;
                end
            end
            ST_PAD: begin
                w_load = w_can_load;
                if (w_load && w_beat_last) begin
                    w_state_next = enable_i ? ST_STREAM : ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Beat payload: zero-extended FIFO word, or all zeros for pad beats.
    always_comb begin
        w_beat_data = '0;
        if (r_state != ST_PAD) begin
            w_beat_data[FIFO_WIDTH-1:0] = fifoDout_i;
        end
        w_beat_user            = '0;
        w_beat_user[TUSER_SOF] = (r_beat_cnt == '0);
        w_beat_user[TUSER_PAD] = (r_state == ST_PAD);
    end

    assign w_skid_in = {w_beat_user, w_beat_last, w_beat_data};

    always_ff @(posedge aclk_i) begin
        if (areset_i) begin
            r_state      <= ST_IDLE;
            r_beat_cnt   <= '0;
            r_flush_pend <= 1'b0;
            r_frame_cnt  <= '0;
        end else begin
            r_state      <= w_state_next;
            r_flush_pend <= w_flush_pend_next;
            if (w_load) begin
                r_beat_cnt <= w_beat_last ? '0 : r_beat_cnt + 1'b1;
            end
            if (w_handshake && m_axis_tlast_o) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
        end
    end

    axis_skid2 #(
        .WIDTH(SKID_W)
    ) u_skid (
        .clk        (aclk_i),
        .srst       (areset_i),
        .i_load     (w_load),
        .i_unload   (w_handshake),
        .i_data     (w_skid_in),
        .o_data     (w_skid_out),
        .o_occupancy(w_occ)
    );

    assign m_axis_tvalid_o = (w_occ != 2'd0);
    assign w_handshake     = m_axis_tvalid_o && m_axis_tready_i;
    assign m_axis_tdata_o  = w_skid_out[AXIS_WIDTH-1:0];
    assign m_axis_tlast_o  = w_skid_out[AXIS_WIDTH];
    assign m_axis_tuser_o  = w_skid_out[AXIS_WIDTH+2:AXIS_WIDTH+1];
    assign fifoRd_o        = w_fifo_rd;
    assign busy_o          = (r_state != ST_IDLE) || (w_occ != 2'd0);
    assign frame_cnt_o     = r_frame_cnt;

endmodule

// File: tb/tb_fifo_axis_framer.sv
// Self-checking bench for fifo_axis_framer: instance A (FRAME_LEN=4) runs the
// directed sequences, instance B (FRAME_LEN=256) runs a randomised stream
// checked against a beat-index model of the framing rules.
module tb_fifo_axis_framer;

    localparam int FW = 100;
    localparam int AW = 128;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- instance A: FRAME_LEN = 4 ----------------
    logic          a_rst, a_en, a_flush, a_tready, a_clr;
    logic          a_empty, a_rd, a_tvalid, a_tlast, a_busy;
    logic [FW-1:0] a_dout;
    logic [AW-1:0] a_tdata;
    logic [1:0]    a_tuser;
    logic [31:0]   a_fcnt;

    logic [FW-1:0] a_mem [0:255];
    int            a_wr     = 0;
    int            a_rd_idx = 0;
    int            a_pops   = 0;
    logic          a_bad_pop = 1'b0;

    assign a_empty = (a_rd_idx == a_wr);
    assign a_dout  = a_mem[a_rd_idx[7:0]];

    always @(posedge clk) begin
        if (a_rd && a_empty) a_bad_pop <= 1'b1;
        if (a_clr) begin
            a_rd_idx <= a_wr;
        end else if (a_rd && !a_empty) begin
            a_rd_idx <= a_rd_idx + 1;
            a_pops   <= a_pops + 1;
        end
    end

    fifo_axis_framer #(.FIFO_WIDTH(FW), .AXIS_WIDTH(AW), .FRAME_LEN(4)) dut_a (
        .aclk_i(clk), .areset_i(a_rst), .enable_i(a_en), .flush_i(a_flush),
        .fifoEmpty_i(a_empty), .fifoDout_i(a_dout), .fifoRd_o(a_rd),
        .m_axis_tvalid_o(a_tvalid), .m_axis_tready_i(a_tready),
        .m_axis_tdata_o(a_tdata), .m_axis_tlast_o(a_tlast),
        .m_axis_tuser_o(a_tuser), .busy_o(a_busy), .frame_cnt_o(a_fcnt)
    );

    logic [AW-1:0] a_rx_data [0:63];
    logic          a_rx_last [0:63];
    logic [1:0]    a_rx_user [0:63];
    int            a_rx_cyc  [0:63];
    int            a_rx_n = 0;

    // Sampled mid-cycle: a beat recorded here completes at the next posedge.
    always @(negedge clk) begin
        if (!a_rst && a_tvalid && a_tready && a_rx_n < 64) begin
            a_rx_data[a_rx_n] = a_tdata;
            a_rx_last[a_rx_n] = a_tlast;
            a_rx_user[a_rx_n] = a_tuser;
            a_rx_cyc[a_rx_n]  = cyc;
            $display("A beat %0d: tdata=%0h tlast=%0b tuser=%02b", a_rx_n, a_tdata, a_tlast, a_tuser);
            a_rx_n = a_rx_n + 1;
        end
    end

    // ---------------- instance B: FRAME_LEN = 256 ----------------
    logic          b_rst, b_en, b_flush, b_tready;
    logic          b_empty, b_rd, b_tvalid, b_tlast, b_busy;
    logic [FW-1:0] b_dout;
    logic [AW-1:0] b_tdata;
    logic [1:0]    b_tuser;
    logic [31:0]   b_fcnt;

    logic [FW-1:0] b_mem [0:1023];
    int            b_wr     = 0;
    int            b_rd_idx = 0;
    logic          b_bad_pop = 1'b0;

    assign b_empty = (b_rd_idx == b_wr);
    assign b_dout  = b_mem[b_rd_idx[9:0]];

    always @(posedge clk) begin
        if (b_rd && b_empty) b_bad_pop <= 1'b1;
        if (b_rd && !b_empty) b_rd_idx <= b_rd_idx + 1;
    end

    fifo_axis_framer #(.FIFO_WIDTH(FW), .AXIS_WIDTH(AW), .FRAME_LEN(256)) dut_b (
        .aclk_i(clk), .areset_i(b_rst), .enable_i(b_en), .flush_i(b_flush),
        .fifoEmpty_i(b_empty), .fifoDout_i(b_dout), .fifoRd_o(b_rd),
        .m_axis_tvalid_o(b_tvalid), .m_axis_tready_i(b_tready),
        .m_axis_tdata_o(b_tdata), .m_axis_tlast_o(b_tlast),
        .m_axis_tuser_o(b_tuser), .busy_o(b_busy), .frame_cnt_o(b_fcnt)
    );

    logic [AW-1:0] b_rx_data [0:1023];
    logic          b_rx_last [0:1023];
    logic [1:0]    b_rx_user [0:1023];
    int            b_rx_n = 0;
    logic          b_stall_prev = 1'b0;
    logic          b_unstable   = 1'b0;
    logic [AW+2:0] b_hold;

    always @(negedge clk) begin
        if (b_stall_prev && (b_tvalid !== 1'b1 || {b_tuser, b_tlast, b_tdata} !== b_hold))
            b_unstable = 1'b1;
        b_stall_prev = !b_rst && b_tvalid && !b_tready;
        b_hold       = {b_tuser, b_tlast, b_tdata};
        if (!b_rst && b_tvalid && b_tready && b_rx_n < 1024) begin
            b_rx_data[b_rx_n] = b_tdata;
            b_rx_last[b_rx_n] = b_tlast;
            b_rx_user[b_rx_n] = b_tuser;
            b_rx_n = b_rx_n + 1;
            if (b_tlast) $display("B frame closed at beat %0d", b_rx_n);
        end
    end

    // ---------------- helpers ----------------
    typedef struct {
        logic [FW-1:0] word_in;
        logic [AW-1:0] exp_data;
        logic          exp_last;
        logic [1:0]    exp_user;
    } vec_t;

    vec_t tbl [8];
    int   base;
    int   p0;
    int   pushed;

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic a_push(input logic [FW-1:0] w);
        a_mem[a_wr[7:0]] = w;
        a_wr = a_wr + 1;
    endtask

    task automatic b_push_random();
        logic [127:0] r;
        r = {$urandom(), $urandom(), $urandom(), $urandom()};
        b_mem[b_wr[9:0]] = r[FW-1:0];
        b_wr = b_wr + 1;
    endtask

    task automatic a_wait_rx(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (a_rx_n < n && k < budget) begin
            step(1);
            k++;
        end
        chk(name, 136'(a_rx_n >= n), 136'(1));
    endtask

    task automatic a_reset();
        a_rst = 1'b1;
        a_clr = 1'b1;
        step(2);
        a_rst = 1'b0;
        a_clr = 1'b0;
    endtask

    task automatic a_chk_zero(input string pfx);
        chk({pfx, "_tvalid"}, 136'(a_tvalid), 136'(0));
        chk({pfx, "_tdata"},  136'(a_tdata),  136'(0));
        chk({pfx, "_tlast"},  136'(a_tlast),  136'(0));
        chk({pfx, "_tuser"},  136'(a_tuser),  136'(0));
        chk({pfx, "_busy"},   136'(a_busy),   136'(0));
        chk({pfx, "_fcnt"},   136'(a_fcnt),   136'(0));
        chk({pfx, "_rd"},     136'(a_rd),     136'(0));
    endtask

    // ---------------- test sequence ----------------
    initial begin
        a_rst = 1'b1; a_en = 1'b0; a_flush = 1'b0; a_tready = 1'b0; a_clr = 1'b0;
        b_rst = 1'b1; b_en = 1'b0; b_flush = 1'b0; b_tready = 1'b0;

        for (int i = 0; i < 8; i++) begin
            tbl[i].word_in  = FW'(i + 1);
            tbl[i].exp_data = AW'(i + 1);
            tbl[i].exp_last = ((i % 4) == 3);
            tbl[i].exp_user = {1'b0, (i % 4) == 0};
        end

        step(3);
        a_chk_zero("reset");
        a_rst = 1'b0;
        b_rst = 1'b0;
        step(1);

        // Two back-to-back frames of 4 from a preloaded FIFO.
        base = a_rx_n;
        for (int i = 0; i < 8; i++) a_push(tbl[i].word_in);
        a_tready = 1'b1;
        a_en     = 1'b1;
        a_wait_rx(base + 8, 100, "two_frames_wait");
        step(1);
        for (int i = 0; i < 8; i++)
            chk($sformatf("two_frames_beat%0d", i),
                136'({a_rx_user[base+i], a_rx_last[base+i], a_rx_data[base+i]}),
                136'({tbl[i].exp_user, tbl[i].exp_last, tbl[i].exp_data}));
        chk("two_frames_fcnt", 136'(a_fcnt), 136'(2));
        chk("two_frames_contiguous", 136'(a_rx_cyc[base+7] - a_rx_cyc[base]), 136'(7));
        a_en = 1'b0;
        a_reset();

        // Back-pressure: tready low for 10 cycles with a full FIFO.
        base = a_rx_n;
        p0   = a_pops;
        for (int i = 0; i < 8; i++) a_push(FW'(32'h11 + i));
        a_tready = 1'b0;
        a_en     = 1'b1;
        step(10);
        chk("stall_pops", 136'(a_pops - p0), 136'(2));
        a_tready = 1'b1;
        a_wait_rx(base + 8, 100, "stall_release_wait");
        for (int i = 0; i < 8; i++)
            chk($sformatf("stall_order%0d", i), 136'(a_rx_data[base+i]), 136'(32'h11 + i));
        chk("stall_total_pops", 136'(a_pops - p0), 136'(8));
        a_en = 1'b0;
        a_reset();

        // Flush a 2-beat partial frame with 2 pad beats.
        base = a_rx_n;
        a_push(FW'(32'h21));
        a_push(FW'(32'h22));
        a_tready = 1'b1;
        a_en     = 1'b1;
        a_wait_rx(base + 2, 50, "flush_data_wait");
        a_en    = 1'b0;
        a_flush = 1'b1;
        step(1);
        a_flush = 1'b0;
        a_wait_rx(base + 4, 50, "flush_pad_wait");
        step(3);
        chk("flush_beat0", 136'({a_rx_user[base], a_rx_last[base], a_rx_data[base]}), 136'({2'b01, 1'b0, AW'(32'h21)}));
        chk("flush_beat1", 136'({a_rx_user[base+1], a_rx_last[base+1], a_rx_data[base+1]}), 136'({2'b00, 1'b0, AW'(32'h22)}));
        chk("flush_pad2",  136'({a_rx_user[base+2], a_rx_last[base+2], a_rx_data[base+2]}), 136'({2'b10, 1'b0, AW'(0)}));
        chk("flush_pad3",  136'({a_rx_user[base+3], a_rx_last[base+3], a_rx_data[base+3]}), 136'({2'b10, 1'b1, AW'(0)}));
        chk("flush_idle_busy", 136'(a_busy), 136'(0));
        chk("flush_fcnt", 136'(a_fcnt), 136'(1));
        a_reset();

        // Enable dropped after beat 1: frame completes from the FIFO, then idles.
        base = a_rx_n;
        a_push(FW'(32'h31));
        a_tready = 1'b1;
        a_en     = 1'b1;
        a_wait_rx(base + 1, 50, "drop_en_first_wait");
        a_en = 1'b0;
        step(5);
        chk("drop_en_stall_busy", 136'(a_busy), 136'(1));
        for (int i = 1; i < 4; i++) a_push(FW'(32'h31 + i));
        a_wait_rx(base + 4, 50, "drop_en_finish_wait");
        step(3);
        chk("drop_en_idle_busy", 136'(a_busy), 136'(0));
        for (int i = 1; i < 4; i++)
            chk($sformatf("drop_en_beat%0d", i),
                136'({a_rx_last[base+i], a_rx_data[base+i]}), 136'({i == 3, AW'(32'h31 + i)}));
        p0 = a_pops;
        a_push(FW'(32'h35));
        step(10);
        chk("drop_en_no_pop", 136'(a_pops - p0), 136'(0));
        chk("drop_en_no_beat", 136'(a_rx_n), 136'(base + 4));
        a_reset();

        // Reset with one buffered entry and beat_cnt = 2.
        base = a_rx_n;
        p0   = a_pops;
        a_push(FW'(32'h41));
        a_push(FW'(32'h42));
        a_tready = 1'b0;
        a_en     = 1'b1;
        step(6);
        chk("rst_pre_pops", 136'(a_pops - p0), 136'(2));
        a_tready = 1'b1;
        step(1);
        a_tready = 1'b0;
        chk("rst_pre_one_beat", 136'(a_rx_n), 136'(base + 1));
        a_rst = 1'b1;
        step(1);
        a_chk_zero("midframe_rst");
        a_rst = 1'b0;
        a_push(FW'(32'h43));
        a_tready = 1'b1;
        a_wait_rx(base + 2, 50, "rst_reenable_wait");
        chk("rst_reenable_sof", 136'({a_rx_user[base+1], a_rx_data[base+1]}), 136'({2'b01, AW'(32'h43)}));
        a_en = 1'b0;

        // Randomised stream on instance B: 1000 words, random tready and gaps.
        pushed = 0;
        b_en   = 1'b1;
        for (int c = 0; c < 20000 && b_rx_n < 1000; c++) begin
            b_tready = 1'($urandom_range(0, 1));
            if (pushed < 1000 && $urandom_range(0, 1) == 1) begin
                b_push_random();
                pushed++;
            end
            step(1);
        end
        b_tready = 1'b1;
        step(3);
        chk("rand_beats_received", 136'(b_rx_n), 136'(1000));
        for (int i = 0; i < 1000; i++) begin
            logic [AW-1:0] ed;
            ed = '0;
            ed[FW-1:0] = b_mem[i];
            chk($sformatf("rand_beat%0d", i),
                136'({b_rx_user[i], b_rx_last[i], b_rx_data[i]}),
                136'({1'b0, (i % 256) == 0, (i % 256) == 255, ed}));
        end
        chk("rand_fcnt", 136'(b_fcnt), 136'(3));
        chk("rand_partial_beats", 136'(b_rx_n - 256 * int'(b_fcnt)), 136'(232));
        chk("rand_busy_midframe", 136'(b_busy), 136'(1));
        chk("rand_stable_under_stall", 136'(b_unstable), 136'(0));
        chk("rand_no_pop_when_empty", 136'(b_bad_pop), 136'(0));
        chk("dir_no_pop_when_empty", 136'(a_bad_pop), 136'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
